mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Processor-side initiator for the word-addressed data memory. It converts load and store requests of byte, halfword or word size into word reads and writes on the memory port.
- Sub-word stores use read-modify-write. Loads return extracted data, sign- or zero-extended.
- Sits between the core's execute/memory stage and the memory's address, data and write-enable interface.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words in the memory. Byte addresses at or above MEM_WORDS*4 are out of range.
- ADDR_W, 32: width of request and memory addresses, in bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse when the request completes
- resp_rdata  out  32  load result, valid while resp_valid is high; 0 for stores and errors
- resp_err  out  1  valid while resp_valid is high: misaligned, out-of-range or reserved size
- mem_address  out  ADDR_W  word-aligned byte address; bits [1:0] always 0
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  combinational read data from memory
- mem_we  out  1  memory write enable, registered

Behaviour:
- Reset: async assertion forces state IDLE and clears all registered outputs to 0 (req_ready is 1 in IDLE). mem_we drops immediately, not at the next edge.
- Reset between READ and WRITE of a sub-word store aborts the store; memory is left unmodified and no response is issued.
- FSM states: IDLE, READ, WRITE, RESP.
- Acceptance: a request is accepted on a clock edge where req_valid && req_ready. The controller registers addr, size, we, unsigned and wdata, then:
  - error condition -> RESP with err = 1; no memory cycle is issued.
  - load -> READ.
  - word store -> WRITE.
  - byte or halfword store -> READ.
- READ (1 cycle): mem_address = {addr[ADDR_W-1:2], 2'b00}, mem_we = 0. The controller captures mem_rdata at the end of the cycle.
  - load -> RESP, with extracted and extended data.
  - sub-word store -> WRITE, with the merged word.
- WRITE (1 cycle): mem_we = 1. mem_address and mem_wdata are held stable for the whole cycle. Next state is RESP.
- RESP (1 cycle): resp_valid = 1, then return to IDLE. The response has no backpressure.
- Latency from accept edge to resp_valid:
  - word load: 2 cycles
  - word store: 2 cycles
  - sub-word load: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Lane selection:
  - byte lane = addr[1:0]; halfword lane = addr[1]. Little-endian: byte 0 is bits [7:0].
  - Merge replaces only the addressed lane(s); other bytes come from the captured read word.
- Error conditions:
  - req_size == 3.
  - addr >= MEM_WORDS*4.
  - misalignment (see Optional Feature).
- mem_we is never high outside WRITE. mem_address and mem_wdata are 0 in IDLE.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 0, returns resp_err = 1 and makes no memory access.
- Undefined: the low address bits are forced to alignment (halfword clears bit 0, word clears bits [1:0]) and the access proceeds normally with no error.

Decomposition:
- Package mem_pkg holds:
  - size encodings SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2.
  - FSM state typedef (IDLE, READ, WRITE, RESP).
- Sub-module mem_lane_unit (combinational) contains:
  - load extraction and sign/zero extension from word, size, offset and unsigned.
  - store merge from old word, new data, size and offset.
- The FSM stays in mem_access_ctrl.

Test Plan:
- Word at 0x10 = 0x8899AABB; byte load unsigned at 0x13 -> resp_rdata = 0x00000088, 2 cycles after accept, resp_err = 0.
- Same word; halfword load signed at 0x12 -> resp_rdata = 0xFFFF8899. Byte load signed at 0x10 -> 0xFFFFFFBB.
- Word 0x11223344 at 0x20; byte store 0xA5 to 0x21 -> exactly one mem_we cycle with mem_wdata = 0x1122A544, resp 3 cycles after accept.
- Word store 0xDEADBEEF to 0x40 -> mem_we high for exactly 1 cycle with mem_address = 0x40, resp at cycle 2; a following word load of 0x40 returns 0xDEADBEEF.
- Misalignment and range:
  - With MEM_MISALIGN_TRAP_EN: word load at 0x42 -> resp_err = 1 after 1 cycle, mem_we never high.
  - Without it: the same load returns the word at 0x40.
  - addr = 0x1000 with MEM_WORDS = 1024 -> resp_err = 1.
- Assert rst during READ of a byte store -> mem_we stays 0, no resp_valid, memory word unchanged, req_ready = 1 after reset release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access controller: access sizes and FSM states.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: load extraction with sign/zero extension, and
// sub-word store merge into a previously read word (little-endian lanes).
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_data_o = word_i;
        case (size_i)
            SIZE_B:  load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SIZE_H:  load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default: load_data_o = word_i;
        endcase
    end

    always_comb begin
        merged_o = word_i;
        case (size_i)
            SIZE_B: begin
                case (off_i)
                    2'd0:    merged_o[7:0]   = store_data_i[7:0];
                    2'd1:    merged_o[15:8]  = store_data_i[7:0];
                    2'd2:    merged_o[23:16] = store_data_i[7:0];
                    default: merged_o[31:24] = store_data_i[7:0];
                endcase
            end
            SIZE_H: begin
                if (off_i[1]) merged_o[31:16] = store_data_i[15:0];
                else          merged_o[15:0]  = store_data_i[15:0];
            end
            default: merged_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-addressed data memory; sub-word stores use read-modify-write.
// Build option MEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses error instead of being aligned down.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_WORDS * 4);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [31:0]       data_q, data_d;
    logic              mem_we_q, mem_we_d;

    logic [ADDR_W-1:0] acc_addr;
    logic              misalign;
    logic              req_err;
    logic [31:0]       load_data;
    logic [31:0]       merged;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        acc_addr = req_addr;
        misalign = ((req_size == SIZE_H) && req_addr[0]) ||
                   ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
    end
`else
    always_comb begin
        acc_addr = req_addr;
        misalign = 1'b0;
        if (req_size == SIZE_H) acc_addr[0]   = 1'b0;
        if (req_size == SIZE_W) acc_addr[1:0] = 2'b00;
    end
`endif

    assign req_err = (req_size == 2'd3) || misalign || ({1'b0, acc_addr} >= ADDR_LIMIT);

    mem_lane_unit u_lane (
        .word_i       (mem_rdata),
        .store_data_i (data_q),
        .size_i       (size_q),
        .off_i        (addr_q[1:0]),
        .unsigned_i   (uns_q),
        .load_data_o  (load_data),
        .merged_o     (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= SIZE_B;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            we_q     <= we_d;
            uns_q    <= uns_d;
            err_q    <= err_d;
            data_q   <= data_d;
            mem_we_q <= mem_we_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        we_d     = we_q;
        uns_d    = uns_q;
        err_d    = err_q;
        data_d   = data_q;
        mem_we_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = acc_addr;
                    size_d = req_size;
                    we_d   = req_we;
                    uns_d  = req_unsigned;
                    err_d  = req_err;
                    data_d = req_wdata;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_we && (req_size == SIZE_W)) begin
                        state_d  = WRITE;
                        mem_we_d = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // data_q holds store data until here, then becomes the merged or loaded word
                if (we_q) begin
                    data_d   = merged;
                    state_d  = WRITE;
                    mem_we_d = 1'b1;
                end else begin
                    data_d  = load_data;
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign mem_we      = mem_we_q;
    assign mem_address = ((state_q == READ) || (state_q == WRITE)) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata   = (state_q == WRITE) ? data_q : 32'h0;
    assign resp_valid  = (state_q == RESP);
    assign resp_err    = (state_q == RESP) && err_q;
    assign resp_rdata  = ((state_q == RESP) && !we_q && !err_q) ? data_q : 32'h0;

endmodule
